// File: rtl/and_gate.sv
`timescale 1ns/1ps
// Two-input AND with registered copy, edge pulses, debounced level and saturating high-time counter.
// Latency: Y is combinational; y_q/y_rise/y_fall/hi_cnt one cycle; y_stable after FILT_LEN agreeing samples.
// Backpressure: none, every cycle is sampled unconditionally.
module and_gate #(
  parameter int CNT_W    = 16,
  parameter int FILT_LEN = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             A,
  input  logic             B,
  output logic             Y,
  output logic             y_q,
  output logic             y_rise,
  output logic             y_fall,
  output logic             y_stable,
  output logic [CNT_W-1:0] hi_cnt,
  output logic             cnt_sat
);

  // Run counter is 8 bits wide because FILT_LEN tops out at 255; the run
  // never needs to hold FILT_LEN itself, only FILT_LEN-1 before toggling.
  localparam logic [7:0]       FILT_LAST = 8'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             y_d;
  logic             rise_d, rise_q;
  logic             fall_d, fall_q;
  logic             stable_d, stable_q;
  logic [7:0]       run_d, run_q;
  logic [CNT_W-1:0] hi_cnt_d, hi_cnt_q;

  // The gate itself: independent of clock and reset.
  assign Y = A & B;

  // Next-state for the sampled copy, edge detectors, debounce and counter.
  always_comb begin
    y_d      = Y;
    rise_d   = Y & ~y_q;
    fall_d   = ~Y & y_q;
    stable_d = stable_q;
    run_d    = '0;
    hi_cnt_d = hi_cnt_q;

    // A sample agreeing with the debounced level restarts the run; the
    // FILT_LEN-th consecutive disagreeing sample flips the level.
    if (Y != stable_q) begin
      if (run_q == FILT_LAST) begin
        stable_d = Y;
      end else begin
        run_d = run_q + 8'd1;
      end
    end

    // Saturate rather than wrap so long high periods stay visible.
    if (Y && !cnt_sat) begin
      hi_cnt_d = hi_cnt_q + CNT_ONE;
    end
  end

  // State registers, cleared immediately by reset assertion.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      y_q      <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      stable_q <= 1'b0;
      run_q    <= '0;
      hi_cnt_q <= '0;
    end else begin
      y_q      <= y_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      stable_q <= stable_d;
      run_q    <= run_d;
      hi_cnt_q <= hi_cnt_d;
    end
  end

  assign y_rise   = rise_q;
  assign y_fall   = fall_q;
  assign y_stable = stable_q;
  assign hi_cnt   = hi_cnt_q;
  assign cnt_sat  = &hi_cnt_q;

endmodule

// File: tb/tb_and_gate.sv
`timescale 1ns/1ps
// Bench for and_gate: three instances (default, CNT_W=4, FILT_LEN=1) share one stimulus.
module tb_and_gate;

  logic clk;
  logic rst_n;
  logic A;
  logic B;

  logic        m_y, m_yq, m_rise, m_fall, m_st, m_sat;
  logic [15:0] m_cnt;
  logic        s_y, s_yq, s_rise, s_fall, s_st, s_sat;
  logic [3:0]  s_cnt;
  logic        f_y, f_yq, f_rise, f_fall, f_st, f_sat;
  logic [15:0] f_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic a;
    logic b;
    logic y;
    logic yq;
    logic rise;
    logic fall;
    logic st;
    int   cnt;
  } vec_t;

  vec_t tbl [19];

  and_gate dut_m (
    .sys_clk(clk), .sys_rst_n(rst_n), .A(A), .B(B), .Y(m_y), .y_q(m_yq),
    .y_rise(m_rise), .y_fall(m_fall), .y_stable(m_st), .hi_cnt(m_cnt), .cnt_sat(m_sat)
  );

  and_gate #(.CNT_W(4)) dut_s (
    .sys_clk(clk), .sys_rst_n(rst_n), .A(A), .B(B), .Y(s_y), .y_q(s_yq),
    .y_rise(s_rise), .y_fall(s_fall), .y_stable(s_st), .hi_cnt(s_cnt), .cnt_sat(s_sat)
  );

  and_gate #(.FILT_LEN(1)) dut_f (
    .sys_clk(clk), .sys_rst_n(rst_n), .A(A), .B(B), .Y(f_y), .y_q(f_yq),
    .y_rise(f_rise), .y_fall(f_fall), .y_stable(f_st), .hi_cnt(f_cnt), .cnt_sat(f_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100us;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_regs_zero(input string tag);
    chk({tag, " m_yq"},   32'(m_yq),   0);
    chk({tag, " m_rise"}, 32'(m_rise), 0);
    chk({tag, " m_fall"}, 32'(m_fall), 0);
    chk({tag, " m_st"},   32'(m_st),   0);
    chk({tag, " m_cnt"},  32'(m_cnt),  0);
    chk({tag, " m_sat"},  32'(m_sat),  0);
    chk({tag, " s_cnt"},  32'(s_cnt),  0);
    chk({tag, " s_sat"},  32'(s_sat),  0);
    chk({tag, " f_st"},   32'(f_st),   0);
    chk({tag, " f_yq"},   32'(f_yq),   0);
  endtask

  initial begin
    int exp_m;
    int exp_s;

    //          a     b     y     yq    rise  fall  st    cnt
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 7};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8};

    // Reset held with clock running; Y must still track A&B.
    rst_n = 1'b0;
    A = 1'b0;
    B = 1'b0;
    #0.2;
    chk("rst y00", 32'(m_y), 0);
    chk_regs_zero("rst a");
    A = 1'b1;
    #1;
    chk("rst y10", 32'(m_y), 0);
    @(posedge clk);
    #1;
    chk_regs_zero("rst b");
    B = 1'b1;
    #1;
    chk("rst y11", 32'(m_y), 1);
    @(posedge clk);
    #1;
    chk_regs_zero("rst c");
    A = 1'b0;
    B = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven cycles from a clean reset.
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      A = tbl[i].a;
      B = tbl[i].b;
      #1;
      chk($sformatf("row%0d m_y", i), 32'(m_y), 32'(tbl[i].y));
      chk($sformatf("row%0d s_y", i), 32'(s_y), 32'(tbl[i].y));
      @(posedge clk);
      #1;
      chk($sformatf("row%0d yq", i),     32'(m_yq),   32'(tbl[i].yq));
      chk($sformatf("row%0d rise", i),   32'(m_rise), 32'(tbl[i].rise));
      chk($sformatf("row%0d fall", i),   32'(m_fall), 32'(tbl[i].fall));
      chk($sformatf("row%0d stable", i), 32'(m_st),   32'(tbl[i].st));
      chk($sformatf("row%0d cnt", i),    32'(m_cnt),  32'(tbl[i].cnt));
      chk($sformatf("row%0d sat", i),    32'(m_sat),  0);
      chk($sformatf("row%0d s_cnt", i),  32'(s_cnt),  32'(tbl[i].cnt));
      chk($sformatf("row%0d f_st", i),   32'(f_st),   32'(tbl[i].yq));
    end

    // Hold Y high for 20 cycles: 4-bit counter saturates at 15.
    exp_m = tbl[18].cnt;
    exp_s = tbl[18].cnt;
    @(negedge clk);
    A = 1'b1;
    B = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      exp_m = exp_m + 1;
      exp_s = (exp_s == 15) ? 15 : exp_s + 1;
      chk($sformatf("sat%0d s_cnt", k), 32'(s_cnt), 32'(exp_s));
      chk($sformatf("sat%0d s_sat", k), 32'(s_sat), 32'(exp_s == 15));
      chk($sformatf("sat%0d m_cnt", k), 32'(m_cnt), 32'(exp_m));
    end
    chk("sat m_sat", 32'(m_sat), 0);

    // Reset mid-count with A=B=1: immediate clear, Y unaffected.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_regs_zero("mid a");
    chk("mid m_y", 32'(m_y), 1);
    @(posedge clk);
    #1;
    chk_regs_zero("mid b");
    chk("mid m_y2", 32'(m_y), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Restart with A=B=1 held: one rise pulse, stable after 4, count from 1.
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rel%0d cnt", k),   32'(m_cnt),  32'(k));
      chk($sformatf("rel%0d rise", k),  32'(m_rise), 32'(k == 1));
      chk($sformatf("rel%0d fall", k),  32'(m_fall), 0);
      chk($sformatf("rel%0d st", k),    32'(m_st),   32'(k >= 4));
      chk($sformatf("rel%0d s_cnt", k), 32'(s_cnt),  32'(k));
      chk($sformatf("rel%0d f_st", k),  32'(f_st),   1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
